conv_coef_sequencer: RTL

- Controller for the 3x3 convolution multiply stage.
- Accepts a serial 8-bit coefficient stream into a shadow bank and commits it to an active bank at start-of-frame. The active bank drives the stage's c1..c9 inputs.
- Tracks raster position of the pixel-window stream and flags which windows are fully inside the image.
- Delays that flag by the multiply-stage latency, so downstream accumulators know which cp products are valid.

---
 rtl/conv_coef_sequencer_pkg.sv | 36 +++
 rtl/conv_coef_sequencer_if.sv | 30 +++
 rtl/conv_coef_sequencer_delay.sv | 26 ++
 rtl/conv_coef_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/conv_coef_sequencer_pkg.sv
// Shared types and constants for the 3x3 convolution coefficient sequencer.
// Macro CONV_SYM_KERNEL_EN selects a 5-coefficient point-symmetric kernel load.
package conv_ctrl_pkg;

    localparam int COEF_W       = 8;
    localparam int NUM_TAPS     = 9;
    localparam int NUM_SYM_TAPS = 5;

`ifdef CONV_SYM_KERNEL_EN
    localparam int LOAD_CNT = NUM_SYM_TAPS;
`else
    localparam int LOAD_CNT = NUM_TAPS;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [0:0] ST_IDLE = 1'(IDLE);
    localparam logic [0:0] ST_RUN  = 1'(RUN);

    typedef logic [COEF_W-1:0] coef_t;

    // c1 lands in the top byte, c9 in the bottom byte.
    function automatic logic [NUM_TAPS*COEF_W-1:0] pack_bank(
        input coef_t b [NUM_TAPS]
    );
        logic [NUM_TAPS*COEF_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_TAPS; i++)
            r[(NUM_TAPS-1-i)*COEF_W +: COEF_W] = b[i];
        return r;
    endfunction

endpackage

// File: rtl/conv_coef_sequencer_if.sv
// Handshake/data bundle between the sequencer and its environment.
// master drives coefficients, sof and pix_valid; slave is the sequencer.
interface conv_coef_sequencer_if;
    import conv_ctrl_pkg::*;

    logic [COEF_W-1:0]          coef_in;
    logic                       coef_valid;
    logic                       coef_ready;
    logic                       sof;
    logic                       pix_valid;
    logic [NUM_TAPS*COEF_W-1:0] coef_bus;
    logic                       win_valid;
    logic                       out_valid;
    logic                       busy;
    logic                       frame_done;
    logic                       sof_err;

    modport master (
        output coef_in, coef_valid, sof, pix_valid,
        input  coef_ready, coef_bus, win_valid, out_valid,
        input  busy, frame_done, sof_err
    );

    modport slave (
        input  coef_in, coef_valid, sof, pix_valid,
        output coef_ready, coef_bus, win_valid, out_valid,
        output busy, frame_done, sof_err
    );

endinterface

// File: rtl/conv_coef_sequencer_delay.sv
// valid_delay_line: DEPTH-stage shift register for a single valid bit.
// Ports: clk, rst (async active-high), d in, q = d delayed DEPTH cycles.
module valid_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++)
                sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/conv_coef_sequencer.sv
// Coefficient bank sequencer and window-valid tracker for a 3x3 conv stage.
// Ports: clk, rst (async active-high), bus (slave: coef load, sof, pix_valid,
// coef_bus, win/out_valid, busy, frame_done, sof_err). Macro: CONV_SYM_KERNEL_EN.
module conv_coef_sequencer
    import conv_ctrl_pkg::*;
#(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int PIPE_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_coef_sequencer_if.slave  bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int IW = $clog2(LOAD_CNT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);
    localparam logic [IW-1:0] IDX_LAST = IW'(LOAD_CNT - 1);

    coef_t          shadow [LOAD_CNT];
    coef_t          active [NUM_TAPS];
    logic [IW-1:0]  idx;
    logic           shadow_full;
    logic [0:0]     state;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic           frame_done_q;
    logic           sof_err_q;

    logic in_run;
    logic xfer;
    logic commit;

    assign in_run = (state == ST_RUN);
    assign xfer   = bus.coef_valid & ~shadow_full;
    // Decided on the registered shadow_full, so a 9th coef and sof
    // arriving together cannot commit.
    assign commit = (state == ST_IDLE) & bus.sof & shadow_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LOAD_CNT; i++)
                shadow[i] <= '0;
            idx         <= '0;
            shadow_full <= 1'b0;
        end else if (xfer) begin
            shadow[idx] <= bus.coef_in;
            if (idx == IDX_LAST) begin
                idx         <= '0;
                shadow_full <= 1'b1;
            end else begin
                idx <= idx + 1'b1;
            end
        end else if (commit) begin
            shadow_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++)
                active[i] <= '0;
        end else if (commit) begin
            for (int i = 0; i < LOAD_CNT; i++)
                active[i] <= shadow[i];
`ifdef CONV_SYM_KERNEL_EN
            // Point symmetry: c6..c9 mirror c4..c1.
            active[5] <= shadow[3];
            active[6] <= shadow[2];
            active[7] <= shadow[1];
            active[8] <= shadow[0];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            col          <= '0;
            row          <= '0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.sof) begin
                        if (shadow_full) begin
                            state <= ST_RUN;
                            col   <= '0;
                            row   <= '0;
                        end else begin
                            sof_err_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.sof)
                        sof_err_q <= 1'b1;
                    if (bus.pix_valid) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row          <= '0;
                                state        <= ST_IDLE;
                                frame_done_q <= 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.coef_ready = ~shadow_full;
    assign bus.coef_bus   = pack_bank(active);
    assign bus.busy       = in_run;
    assign bus.frame_done = frame_done_q;
    assign bus.sof_err    = sof_err_q;
    assign bus.win_valid  = in_run & bus.pix_valid
                          & (col >= COL_MIN) & (row >= ROW_MIN);

    valid_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .d   (bus.win_valid),
        .q   (bus.out_valid)
    );

endmodule
